// File: rtl/mem_port_ctrl_if.sv
// Request/response bundle between the pipeline memory stage (master)
// and mem_port_ctrl (slave).
interface mem_port_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Load/store port controller: byte-addressed requests to a 64-bit RAM with
// load extension. Define MISALIGN_TRAP_EN to fault misaligned accesses.
module mem_port_ctrl #(
  parameter int unsigned MEM_DEPTH = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  mem_port_ctrl_if.slave                bus,
  output logic                          mem_ren,
  output logic                          mem_wen,
  output logic [$clog2(MEM_DEPTH)-4:0]  mem_addr,
  output logic [63:0]                   mem_wdata,
  output logic [7:0]                    mem_wmask,
  input  logic [63:0]                   mem_rdata,
  input  logic                          mem_valid
);
  localparam int unsigned AB = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [2:0]  off_q;
  logic [7:0]  wmask_q;

  logic [2:0]  amask;
  logic [7:0]  base_mask;
  logic [2:0]  off_eff;
  logic        fault_now;
  logic [63:0] shifted;
  logic [63:0] load_ext;

  always_comb begin
    amask     = 3'd0;
    base_mask = 8'h01;
    case (bus.req_size)
      2'd0: begin amask = 3'd0; base_mask = 8'h01; end
      2'd1: begin amask = 3'd1; base_mask = 8'h03; end
      2'd2: begin amask = 3'd3; base_mask = 8'h0F; end
      default: begin amask = 3'd7; base_mask = 8'hFF; end
    endcase
`ifdef MISALIGN_TRAP_EN
    off_eff   = bus.req_addr[2:0];
    fault_now = (bus.req_addr >= 64'(MEM_DEPTH)) || ((bus.req_addr[2:0] & amask) != 3'd0);
`else
    // Without the trap the low offset bits are dropped to the natural alignment.
    off_eff   = bus.req_addr[2:0] & ~amask;
    fault_now = (bus.req_addr >= 64'(MEM_DEPTH));
`endif
  end

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE) && !rst;
    mem_ren       = (state == S_ACCESS) && !we_q;
    mem_wen       = (state == S_ACCESS) && we_q;
    mem_wmask     = (state == S_ACCESS) ? wmask_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= '0;
      off_q          <= '0;
      wmask_q        <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            off_q   <= off_eff;
            wmask_q <= base_mask << off_eff;
            if (fault_now) begin
              state          <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_fault <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state     <= S_ACCESS;
              mem_addr  <= bus.req_addr[AB-1:3];
              mem_wdata <= bus.req_wdata << {off_eff, 3'b000};
            end
          end
        end
        S_ACCESS: begin
          if (mem_valid) begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_fault <= 1'b0;
            bus.resp_rdata <= we_q ? '0 : load_ext;
          end
        end
        S_RESP: begin
          state          <= S_IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
